// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - registered instruction decode stage with two-entry skid buffer
module ir_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_instr_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_rd_we,
  output logic            out_illegal
);

  // Instruction type encoding shared with the immediate generator.
  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_S = 3'd2;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_ir_q, out_ir_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [2:0]      out_type_q, out_type_d;
  logic            out_rd_we_q, out_rd_we_d;
  logic            out_illegal_q, out_illegal_d;

  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_ir_q, skid_ir_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [2:0]      skid_type_q, skid_type_d;
  logic            skid_rd_we_q, skid_rd_we_d;
  logic            skid_illegal_q, skid_illegal_d;

  logic [2:0] dec_type;
  logic       dec_rd_we;
  logic       dec_illegal;
  logic       accept;
  logic       drain;

  assign accept = in_valid && !skid_valid_q;
  assign drain  = out_valid_q && out_ready;

  // Classify the incoming opcode; unknown opcodes report as illegal R-type.
  always_comb begin
    dec_type    = INSTR_R;
    dec_illegal = 1'b0;
    case (in_ir[6:0])
      7'b0110011: dec_type = INSTR_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: dec_type = INSTR_I;
      7'b0100011: dec_type = INSTR_S;
      7'b1100011: dec_type = INSTR_B;
      7'b0110111, 7'b0010111: dec_type = INSTR_U;
      7'b1101111: dec_type = INSTR_J;
      default:    dec_illegal = 1'b1;
    endcase
    dec_rd_we = !(dec_illegal || dec_type == INSTR_S || dec_type == INSTR_B);
  end

  // Move entries between input, SKID and OUT; flush wins over everything.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_ir_d       = out_ir_q;
    out_pc_d       = out_pc_q;
    out_type_d     = out_type_q;
    out_rd_we_d    = out_rd_we_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_ir_d      = skid_ir_q;
    skid_pc_d      = skid_pc_q;
    skid_type_d    = skid_type_q;
    skid_rd_we_d   = skid_rd_we_q;
    skid_illegal_d = skid_illegal_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_ir_d      = skid_ir_q;
        out_pc_d      = skid_pc_q;
        out_type_d    = skid_type_q;
        out_rd_we_d   = skid_rd_we_q;
        out_illegal_d = skid_illegal_q;
        // accept is always 0 here (in_ready low), kept for clarity.
        skid_valid_d  = accept;
        if (accept) begin
          skid_ir_d      = in_ir;
          skid_pc_d      = in_pc;
          skid_type_d    = dec_type;
          skid_rd_we_d   = dec_rd_we;
          skid_illegal_d = dec_illegal;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_ir_d      = in_ir;
          out_pc_d      = in_pc;
          out_type_d    = dec_type;
          out_rd_we_d   = dec_rd_we;
          out_illegal_d = dec_illegal;
        end
      end
    end else if (accept) begin
      skid_valid_d   = 1'b1;
      skid_ir_d      = in_ir;
      skid_pc_d      = in_pc;
      skid_type_d    = dec_type;
      skid_rd_we_d   = dec_rd_we;
      skid_illegal_d = dec_illegal;
    end
  end

  // State registers for both buffer entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_ir_q       <= '0;
      out_pc_q       <= '0;
      out_type_q     <= INSTR_R;
      out_rd_we_q    <= 1'b0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_ir_q      <= '0;
      skid_pc_q      <= '0;
      skid_type_q    <= INSTR_R;
      skid_rd_we_q   <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_ir_q       <= out_ir_d;
      out_pc_q       <= out_pc_d;
      out_type_q     <= out_type_d;
      out_rd_we_q    <= out_rd_we_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_ir_q      <= skid_ir_d;
      skid_pc_q      <= skid_pc_d;
      skid_type_q    <= skid_type_d;
      skid_rd_we_q   <= skid_rd_we_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

  assign in_ready       = !skid_valid_q;
  assign out_valid      = out_valid_q;
  assign out_ir         = out_ir_q;
  assign out_pc         = out_pc_q;
  assign out_instr_type = out_type_q;
  assign out_rd_we      = out_rd_we_q;
  assign out_illegal    = out_illegal_q;
  assign out_rs1        = out_ir_q[19:15];
  assign out_rs2        = out_ir_q[24:20];
  assign out_rd         = out_ir_q[11:7];
  assign out_funct3     = out_ir_q[14:12];
  assign out_funct7     = out_ir_q[31:25];

endmodule
